// File: rtl/thcattus_seg7_mux_driver.sv
// Multiplexed 7-segment driver: time-slotted digit scan with dead-time, PWM brightness,
// per-digit blanking/blinking and frame-aligned shadow registers so inputs never tear.
module thcattus_seg7_mux_driver #(
    parameter int DIGITS          = 4,
    parameter int CLOCK_FREQ      = 33_334_000,
    parameter int REFRESH_RATE    = 10_000,
    parameter int BLANK_TICKS     = 8,
    parameter int BLINK_FRAMES    = 2048,
    parameter int SEG_ACTIVE_LOW  = 1,
    parameter int COM_ACTIVE_HIGH = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DIGITS*4-1:0]   data,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank_mask,
    input  logic [DIGITS-1:0]     blink_mask,
    input  logic [3:0]            brightness,
    output logic [6:0]            segment,
    output logic                  dp,
    output logic [DIGITS-1:0]     common,
    output logic                  frame_start
);
    localparam int SLOT_TICKS = CLOCK_FREQ / REFRESH_RATE;
    localparam int SLOT_W     = (SLOT_TICKS > 1) ? $clog2(SLOT_TICKS) : 1;
    localparam int IDX_W      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int FRM_W      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic SEG_INV  = (SEG_ACTIVE_LOW != 0);
    localparam logic COM_INV  = (COM_ACTIVE_HIGH == 0);

    logic [SLOT_W-1:0]     r_slot_cnt;
    logic [IDX_W-1:0]      r_digit_idx;
    logic [3:0]            r_pwm_cnt;
    logic                  r_blink_phase;
    logic [FRM_W-1:0]      r_frame_cnt;
    logic                  r_load_pending;
    logic [DIGITS*4-1:0]   r_sh_data;
    logic [DIGITS-1:0]     r_sh_dp;
    logic [DIGITS-1:0]     r_sh_blank;
    logic [DIGITS-1:0]     r_sh_blink;
    logic [3:0]            r_sh_bright;
    logic [6:0]            r_segment;
    logic                  r_dp;
    logic [DIGITS-1:0]     r_common;

    logic                  w_slot_wrap;
    logic                  w_last_digit;
    logic                  w_frame_wrap;
    logic                  w_load;
    logic [3:0]            w_nibble;
    logic                  w_dp_req;
    logic                  w_blank;
    logic                  w_blink;
    logic [DIGITS-1:0]     w_com_onehot;
    logic [6:0]            w_glyph;
    logic                  w_on;

    assign w_slot_wrap  = (r_slot_cnt == SLOT_W'(SLOT_TICKS - 1));
    assign w_last_digit = (r_digit_idx == IDX_W'(DIGITS - 1));
    assign w_frame_wrap = w_slot_wrap && w_last_digit;
    // Shadows also load once right after reset so the first frame shows fresh inputs.
    assign w_load       = !reset && (r_load_pending || w_frame_wrap);

    always_comb begin
        w_nibble     = 4'd0;
        w_dp_req     = 1'b0;
        w_blank      = 1'b0;
        w_blink      = 1'b0;
        w_com_onehot = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_digit_idx == IDX_W'(i)) begin
                w_nibble        = r_sh_data[i*4 +: 4];
                w_dp_req        = r_sh_dp[i];
                w_blank         = r_sh_blank[i];
                w_blink         = r_sh_blink[i];
                w_com_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        case (w_nibble)
            4'h0:    w_glyph = 7'h7E;
            4'h1:    w_glyph = 7'h30;
            4'h2:    w_glyph = 7'h6D;
            4'h3:    w_glyph = 7'h79;
            4'h4:    w_glyph = 7'h33;
            4'h5:    w_glyph = 7'h5B;
            4'h6:    w_glyph = 7'h5F;
            4'h7:    w_glyph = 7'h70;
            4'h8:    w_glyph = 7'h7F;
            4'h9:    w_glyph = 7'h7B;
            4'hA:    w_glyph = 7'h77;
            4'hB:    w_glyph = 7'h1F;
            4'hC:    w_glyph = 7'h4E;
            4'hD:    w_glyph = 7'h3D;
            4'hE:    w_glyph = 7'h4F;
            default: w_glyph = 7'h47;
        endcase
    end

    assign w_on = (32'(r_slot_cnt) >= BLANK_TICKS) && (r_pwm_cnt < r_sh_bright) &&
                  !w_blank && !(w_blink && r_blink_phase);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_slot_cnt     <= '0;
            r_digit_idx    <= '0;
            r_pwm_cnt      <= 4'd0;
            r_blink_phase  <= 1'b0;
            r_frame_cnt    <= '0;
            r_load_pending <= 1'b1;
            r_sh_data      <= '0;
            r_sh_dp        <= '0;
            r_sh_blank     <= '0;
            r_sh_blink     <= '0;
            r_sh_bright    <= 4'd0;
        end else begin
            r_slot_cnt     <= w_slot_wrap ? '0 : r_slot_cnt + 1'b1;
            if (w_slot_wrap) begin
                r_digit_idx <= w_last_digit ? '0 : r_digit_idx + 1'b1;
            end
            r_pwm_cnt      <= (r_pwm_cnt == 4'd14) ? 4'd0 : r_pwm_cnt + 4'd1;
            if (w_frame_wrap) begin
                if (r_frame_cnt == FRM_W'(BLINK_FRAMES - 1)) begin
                    r_frame_cnt   <= '0;
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_frame_cnt   <= r_frame_cnt + 1'b1;
                end
            end
            r_load_pending <= 1'b0;
            if (w_load) begin
                r_sh_data   <= data;
                r_sh_dp     <= dp_in;
                r_sh_blank  <= blank_mask;
                r_sh_blink  <= blink_mask;
                r_sh_bright <= brightness;
            end
        end
    end

    // Polarity is applied only here; everything upstream is active-high.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_segment <= {7{SEG_INV}};
            r_dp      <= SEG_INV;
            r_common  <= {DIGITS{COM_INV}};
        end else begin
            r_segment <= (w_on ? w_glyph : 7'd0) ^ {7{SEG_INV}};
            r_dp      <= (w_on && w_dp_req) ^ SEG_INV;
            r_common  <= (w_on ? w_com_onehot : '0) ^ {DIGITS{COM_INV}};
        end
    end

    assign segment     = r_segment;
    assign dp          = r_dp;
    assign common      = r_common;
    assign frame_start = w_load;
endmodule

// File: tb/tb_thcattus_seg7_mux_driver.sv
// Bench for thcattus_seg7_mux_driver: a 4-digit active-low instance and a 1-digit
// inverted-polarity instance, checked every cycle against a time-indexed model.
module tb_thcattus_seg7_mux_driver;
    localparam int SLOT  = 16;
    localparam int BLANK = 2;
    localparam int BF    = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] d0 = 16'h3A51;
    logic [3:0]  dpi0 = 4'd0, bl0 = 4'd0, bk0 = 4'd0, br0 = 4'd15;
    logic [6:0]  seg0;
    logic        dp0, fs0;
    logic [3:0]  com0;
    logic [3:0]  d1 = 4'h8;
    logic [0:0]  dpi1 = 1'b1, bl1 = 1'b0, bk1 = 1'b0;
    logic [3:0]  br1 = 4'd15;
    logic [6:0]  seg1;
    logic        dp1, fs1;
    logic [0:0]  com1;

    logic [12:0] exp_q0[$];
    logic [12:0] exp_q1[$];
    int          n_cmp = 0;
    int          n_err = 0;

    int          m_c[2];
    logic [12:0] m_nxt[2];
    logic [15:0] s_d[2];
    logic [3:0]  s_dp[2], s_bl[2], s_bk[2], s_br[2];
    int          act_cnt[4];
    int          u1_cnt;
    int          meas_frame;

    // a..g hand-derived from the segment letter lists, a = bit6
    logic [6:0] glyph_tab [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

    thcattus_seg7_mux_driver #(
        .DIGITS(4), .CLOCK_FREQ(1600), .REFRESH_RATE(100), .BLANK_TICKS(BLANK),
        .BLINK_FRAMES(BF), .SEG_ACTIVE_LOW(1), .COM_ACTIVE_HIGH(1)
    ) u0 (
        .clk(clk), .reset(reset), .data(d0), .dp_in(dpi0), .blank_mask(bl0),
        .blink_mask(bk0), .brightness(br0), .segment(seg0), .dp(dp0),
        .common(com0), .frame_start(fs0)
    );

    thcattus_seg7_mux_driver #(
        .DIGITS(1), .CLOCK_FREQ(1600), .REFRESH_RATE(100), .BLANK_TICKS(BLANK),
        .BLINK_FRAMES(BF), .SEG_ACTIVE_LOW(0), .COM_ACTIVE_HIGH(0)
    ) u1 (
        .clk(clk), .reset(reset), .data(d1), .dp_in(dpi1), .blank_mask(bl1),
        .blink_mask(bk1), .brightness(br1), .segment(seg1), .dp(dp1),
        .common(com1), .frame_start(fs1)
    );

    always #5 clk = ~clk;

    task automatic check13(input string name, input logic [12:0] act, input logic [12:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 30)
                $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic report_timeout(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // Expected outputs for cycle c (counted from reset release) use pure time arithmetic.
    task automatic model_step(input int k, input int dig, input logic rst,
                              input logic [15:0] d, input logic [3:0] dpi, input logic [3:0] bl,
                              input logic [3:0] bk, input logic [3:0] br,
                              input bit seg_low, input bit com_high, output logic [12:0] e);
        int c, frame_len, slot, di, pwm, ph;
        logic on, fs, dpo;
        logic [6:0] seg;
        logic [3:0] com, com_mask;
        frame_len = SLOT * dig;
        com_mask  = 4'((1 << dig) - 1);
        on = 1'b0; fs = 1'b0; di = 0;
        if (!rst) begin
            c     = m_c[k];
            fs    = (c == 0) || (c % frame_len == frame_len - 1);
            slot  = c % SLOT;
            di    = (c / SLOT) % dig;
            pwm   = c % 15;
            ph    = (c / (frame_len * BF)) % 2;
            on    = (slot >= BLANK) && (pwm < int'(s_br[k])) && !s_bl[k][di] &&
                    !(s_bk[k][di] && ph == 1);
        end
        e   = {fs, m_nxt[k][11:0]};
        seg = on ? glyph_tab[s_d[k][di*4 +: 4]] : 7'd0;
        dpo = on && s_dp[k][di];
        com = on ? 4'(1 << di) : 4'd0;
        if (seg_low) begin
            seg = ~seg;
            dpo = ~dpo;
        end
        if (!com_high) com = ~com & com_mask;
        m_nxt[k] = {1'b0, dpo, seg, com};
        if (rst) begin
            m_c[k] = 0;
            s_d[k] = '0; s_dp[k] = '0; s_bl[k] = '0; s_bk[k] = '0; s_br[k] = '0;
        end else begin
            if (fs) begin
                s_d[k] = d; s_dp[k] = dpi; s_bl[k] = bl; s_bk[k] = bk; s_br[k] = br;
            end
            m_c[k]++;
        end
    endtask

    // Expected-value producer: runs just after inputs settle each cycle.
    initial begin
        logic [12:0] e;
        @(posedge clk); #2;
        model_step(0, 4, 1'b1, d0, dpi0, bl0, bk0, br0, 1'b1, 1'b1, e);
        model_step(1, 1, 1'b1, {12'd0, d1}, {3'd0, dpi1}, {3'd0, bl1}, {3'd0, bk1}, br1, 1'b0, 1'b0, e);
        forever begin
            @(posedge clk); #2;
            model_step(0, 4, reset, d0, dpi0, bl0, bk0, br0, 1'b1, 1'b1, e);
            exp_q0.push_back(e);
            model_step(1, 1, reset, {12'd0, d1}, {3'd0, dpi1}, {3'd0, bl1}, {3'd0, bk1}, br1, 1'b0, 1'b0, e);
            exp_q1.push_back(e);
        end
    end

    // Monitor: the DUT presents a display state every cycle.
    initial begin
        logic [12:0] e;
        forever begin
            @(negedge clk);
            if (exp_q0.size() > 0) begin
                e = exp_q0.pop_front();
                check13("u0_out", {fs0, dp0, seg0, com0}, e);
            end
            if (exp_q1.size() > 0) begin
                e = exp_q1.pop_front();
                check13("u1_out", {fs1, dp1, seg1, 3'b000, com1}, e);
            end
        end
    end

    // Counts active-common cycles over the 64 output cycles of one u0 frame.
    task automatic measure_frame(input bit back_to_back);
        int guard;
        if (!back_to_back) begin
            guard = 0;
            @(negedge clk);
            while (!fs0 && guard < 200) begin
                @(negedge clk);
                guard++;
            end
            if (!fs0) report_timeout("frame_start_wait");
            @(negedge clk);
        end
        meas_frame = m_c[0] / 64;
        for (int i = 0; i < 4; i++) act_cnt[i] = 0;
        u1_cnt = 0;
        repeat (64) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) act_cnt[i] += int'(com0[i]);
            u1_cnt += int'(!com1[0]);
        end
    endtask

    task automatic wait_phase(input int ph, input string name);
        int guard = 0;
        @(posedge clk);
        while ((m_c[0] % 64 != ph) && guard < 200) begin
            @(posedge clk);
            guard++;
        end
        if (m_c[0] % 64 != ph) report_timeout(name);
    endtask

    initial begin
        repeat (4) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);

        // Full brightness scan of 3A51
        measure_frame(1'b0);
        for (int i = 0; i < 4; i++) check_int($sformatf("b15_cnt_d%0d", i), act_cnt[i], 14);
        check_int("u1_on_cnt", u1_cnt, 56);

        // Partial duty with dp and a blanked digit
        @(posedge clk); #1;
        br0 = 4'd5; dpi0 = 4'b0101; bl0 = 4'b1000;
        repeat (140) @(posedge clk);

        // Zero brightness never lights
        #1;
        br0 = 4'd0; dpi0 = 4'd0; bl0 = 4'd0;
        measure_frame(1'b0);
        for (int i = 0; i < 4; i++) check_int($sformatf("b0_cnt_d%0d", i), act_cnt[i], 0);

        // Mid-frame data change must wait for the next frame boundary
        @(posedge clk); #1;
        br0 = 4'd15; d0 = 16'h1111;
        repeat (70) @(posedge clk);
        wait_phase(20, "mid_frame_wait");
        #1 d0 = 16'h2222;
        repeat (150) @(posedge clk);

        // Blink digit 1 every frame
        #1;
        d0 = 16'h3A51; bk0 = 4'b0010;
        measure_frame(1'b0);
        check_int("blink_a_d1", act_cnt[1], (meas_frame % 2 == 0) ? 14 : 0);
        check_int("blink_a_d0", act_cnt[0], 14);
        measure_frame(1'b1);
        check_int("blink_b_d1", act_cnt[1], (meas_frame % 2 == 0) ? 14 : 0);
        check_int("blink_b_d2", act_cnt[2], 14);

        // Reset at slot 7 of digit 2
        @(posedge clk); #1;
        bk0 = 4'd0;
        wait_phase(39, "mid_slot_wait");
        #1 reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check13("rst_next_cycle", {fs0, dp0, seg0, com0}, {1'b0, 1'b1, 7'h7F, 4'h0});
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (100) @(posedge clk);

        @(negedge clk); #1;
        check_int("q0_drained", exp_q0.size(), 0);
        check_int("q1_drained", exp_q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
